// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants, also used by keycode consumers
// for the HID values they compare against.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2State_t;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam logic [7:0] SET2_R     = 8'h2D;
   localparam logic [7:0] SET2_W     = 8'h1D;
   localparam logic [7:0] SET2_A     = 8'h1C;
   localparam logic [7:0] SET2_S     = 8'h1B;
   localparam logic [7:0] SET2_D     = 8'h23;
   localparam logic [7:0] SET2_SPACE = 8'h29;

   localparam logic [7:0] HID_NONE  = 8'h00;
   localparam logic [7:0] HID_R     = 8'd21;
   localparam logic [7:0] HID_W     = 8'h1A;
   localparam logic [7:0] HID_A     = 8'h04;
   localparam logic [7:0] HID_S     = 8'h16;
   localparam logic [7:0] HID_D     = 8'h07;
   localparam logic [7:0] HID_SPACE = 8'h2C;

   // A PS/2 frame is valid when data plus parity holds an odd number of ones.
   function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
      return ^{dataByte, parityBit};
   endfunction

endpackage

// File: rtl/ps2_set2_to_hid.sv
// Combinational translation of the few scan-set-2 codes the game uses into
// HID usage codes; everything else maps to zero.
module ps2_set2_to_hid
   import ps2_pkg::*;
(
   input  logic [7:0] i_set2Code,
   output logic [7:0] o_hidCode
);

   always_comb begin
      o_hidCode = HID_NONE;
      case (i_set2Code)
         SET2_R:     o_hidCode = HID_R;
         SET2_W:     o_hidCode = HID_W;
         SET2_A:     o_hidCode = HID_A;
         SET2_S:     o_hidCode = HID_S;
         SET2_D:     o_hidCode = HID_D;
         SET2_SPACE: o_hidCode = HID_SPACE;
         default:    o_hidCode = HID_NONE;
      endcase
   end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames and
// tracks make/break sequences to present the currently held mapped key.
module ps2_keycode_receiver
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
)
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_pressed,
   output logic       frame_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic          r_clkSync1;
   logic          r_clkSync2;
   logic          r_clkPrev;
   logic          r_dataSync1;
   logic          r_dataSync2;

   ps2State_t     r_state;
   ps2State_t     w_nextState;
   logic [2:0]    r_bitCount;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic [CW-1:0] r_toCount;

   logic          r_byteValid;
   logic [7:0]    r_byte;
   logic          r_breakPending;
   logic          r_extPending;

   logic          w_fall;
   logic          w_bit;
   logic          w_timeout;
   logic          w_clearBits;
   logic          w_shiftEn;
   logic          w_parityEn;
   logic          w_frameOk;
   logic          w_frameBad;
   logic [7:0]    w_mapped;

   // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_clkSync1  <= 1'b1;
         r_clkSync2  <= 1'b1;
         r_clkPrev   <= 1'b1;
         r_dataSync1 <= 1'b1;
         r_dataSync2 <= 1'b1;
      end else begin
         r_clkSync1  <= ps2_clk;
         r_clkSync2  <= r_clkSync1;
         r_clkPrev   <= r_clkSync2;
         r_dataSync1 <= ps2_data;
         r_dataSync2 <= r_dataSync1;
      end
   end

   assign w_fall    = r_clkPrev & ~r_clkSync2;
   assign w_bit     = r_dataSync2;
   assign w_timeout = (r_state != IDLE) && !w_fall && (r_toCount == TO_LAST);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_clearBits = 1'b0;
      w_shiftEn   = 1'b0;
      w_parityEn  = 1'b0;
      w_frameOk   = 1'b0;
      w_frameBad  = 1'b0;
      if (w_timeout) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_fall && !w_bit) begin
                  w_nextState = DATA;
                  w_clearBits = 1'b1;
               end
            end
            DATA: begin
               if (w_fall) begin
                  w_shiftEn = 1'b1;
                  if (r_bitCount == 3'd7) begin
                     w_nextState = PARITY;
                  end
               end
            end
            PARITY: begin
               if (w_fall) begin
                  w_parityEn  = 1'b1;
                  w_nextState = STOP;
               end
            end
            STOP: begin
               if (w_fall) begin
                  if (w_bit && oddParityOk(r_shift, r_parity)) begin
                     w_frameOk = 1'b1;
                  end else begin
                     w_frameBad = 1'b1;
                  end
                  w_nextState = IDLE;
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_bitCount  <= 3'd0;
         r_shift     <= 8'h00;
         r_parity    <= 1'b0;
         r_toCount   <= '0;
         r_byteValid <= 1'b0;
         r_byte      <= 8'h00;
         frame_err   <= 1'b0;
      end else begin
         if (w_clearBits) begin
            r_bitCount <= 3'd0;
         end else if (w_shiftEn) begin
            r_shift    <= {w_bit, r_shift[7:1]};
            r_bitCount <= r_bitCount + 3'd1;
         end
         if (w_parityEn) begin
            r_parity <= w_bit;
         end
         if ((r_state == IDLE) || w_fall || w_timeout) begin
            r_toCount <= '0;
         end else begin
            r_toCount <= r_toCount + CW'(1);
         end
         r_byteValid <= w_frameOk;
         if (w_frameOk) begin
            r_byte <= r_shift;
         end
         frame_err <= w_frameBad | w_timeout;
      end
   end

   ps2_set2_to_hid u_map (
      .i_set2Code (r_byte),
      .o_hidCode  (w_mapped)
   );

   // Prefix bytes arm flags that qualify the next ordinary byte; a bad or
   // abandoned frame drops them so a lost F0 cannot turn a make into a break.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         keycode        <= HID_NONE;
         key_pressed    <= 1'b0;
         r_breakPending <= 1'b0;
         r_extPending   <= 1'b0;
      end else begin
         key_pressed <= 1'b0;
         if (r_byteValid) begin
            if (r_byte == PS2_BREAK) begin
               r_breakPending <= 1'b1;
            end else if (r_byte == PS2_EXT) begin
               r_extPending <= 1'b1;
            end else begin
               r_breakPending <= 1'b0;
               r_extPending   <= 1'b0;
               if (!r_extPending) begin
                  if (r_breakPending) begin
                     if ((w_mapped == keycode) && (keycode != HID_NONE)) begin
                        keycode <= HID_NONE;
                     end
                  end else if (w_mapped != HID_NONE) begin
                     keycode     <= w_mapped;
                     key_pressed <= (w_mapped != keycode);
                  end
               end
            end
         end
         if (w_frameBad || w_timeout) begin
            r_breakPending <= 1'b0;
            r_extPending   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Scoreboard bench for the PS/2 keycode receiver, driving bit-level PS/2
// frames on the pins and comparing keycode and pulse counts per frame.
module tb_ps2_keycode_receiver;

   localparam int TIMEOUT = 300;
   localparam int HALF    = 20;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic [7:0] keycode;
   logic       keyPressed;
   logic       frameErr;

   ps2_keycode_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .ps2_clk     (ps2Clk),
      .ps2_data    (ps2Data),
      .keycode     (keycode),
      .key_pressed (keyPressed),
      .frame_err   (frameErr)
   );

   always #10 Clk = ~Clk;

   typedef struct {
      logic [7:0] code;
      bit         parOk;
      bit         stopOk;
      logic [7:0] kc;
      int         pulses;
      int         errs;
   } frame_t;

   frame_t sb[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lastFallCyc = 0;
   int pulseCount = 0;
   int errCount = 0;
   int lastPulseCyc = -1;
   int lastErrCyc = -1;
   int widthViol = 0;
   int overlapViol = 0;
   bit prevKp = 1'b0;
   bit prevFe = 1'b0;

   // Cycle counter and output monitor; outputs are sampled on the falling edge.
   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (keyPressed === 1'b1) begin
         pulseCount++;
         lastPulseCyc = cyc;
         if (prevKp) widthViol++;
      end
      if (frameErr === 1'b1) begin
         errCount++;
         lastErrCyc = cyc;
         if (prevFe) widthViol++;
      end
      if (keyPressed === 1'b1 && frameErr === 1'b1) overlapViol++;
      prevKp = (keyPressed === 1'b1);
      prevFe = (frameErr === 1'b1);
   end

   initial begin
      repeat (90000) @(posedge Clk);
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic frame_t mk(input logic [7:0] code, input bit parOk, input bit stopOk,
                                 input logic [7:0] kc, input int pulses, input int errs);
      frame_t f;
      f.code = code; f.parOk = parOk; f.stopOk = stopOk;
      f.kc = kc; f.pulses = pulses; f.errs = errs;
      return f;
   endfunction

   task automatic sendFrame(input logic [7:0] code, input bit parOk, input bit stopOk, input int nbits);
      logic [10:0] bits;
      logic        par;
      par  = parOk ? ~^code : ^code;
      bits = {stopOk, par, code, 1'b0};
      for (int k = 0; k < nbits; k++) begin
         ps2Data = bits[k];
         repeat (HALF) @(negedge Clk);
         ps2Clk = 1'b0;
         lastFallCyc = cyc;
         repeat (HALF) @(negedge Clk);
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
      repeat (3 * HALF) @(negedge Clk);
   endtask

   task automatic applyStimulus(input frame_t f);
      sb.push_back(f);
      sendFrame(f.code, f.parOk, f.stopOk, 11);
   endtask

   task automatic test_reset();
      int p0, e0;
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      vectors++;
      if (keycode !== 8'h00 || keyPressed !== 1'b0 || frameErr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_values: got kc=%h kp=%b fe=%b expected kc=00 kp=0 fe=0",
                  keycode, keyPressed, frameErr);
      end
      Reset = 1'b0;
      p0 = pulseCount; e0 = errCount;
      repeat (2000) @(negedge Clk);
      vectors++;
      if (pulseCount != p0 || errCount != e0 || keycode !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_idle: got pulses=%0d errs=%0d kc=%h expected 0 0 00",
                  pulseCount - p0, errCount - e0, keycode);
      end
   endtask

   task automatic test_make_r();
      frame_t exp;
      int p0, e0;
      p0 = pulseCount; e0 = errCount;
      applyStimulus(mk(8'h2D, 1, 1, 8'h15, 1, 0));
      exp = sb.pop_front();
      vectors++;
      if (keycode !== exp.kc) begin
         miscompares++;
         $display("[TB] FAIL make_r keycode: got %h expected %h", keycode, exp.kc);
      end
      vectors++;
      if (pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
         miscompares++;
         $display("[TB] FAIL make_r pulses: got kp=%0d fe=%0d expected kp=%0d fe=%0d",
                  pulseCount - p0, errCount - e0, exp.pulses, exp.errs);
      end
      vectors++;
      if (lastPulseCyc != lastFallCyc + 4) begin
         miscompares++;
         $display("[TB] FAIL make_r latency: got %0d cycles expected 4", lastPulseCyc - lastFallCyc);
      end
   endtask

   task automatic test_overlap();
      frame_t seq[$];
      frame_t exp;
      int p0, e0;
      seq.push_back(mk(8'h1D, 1, 1, 8'h1A, 1, 0));
      seq.push_back(mk(8'h2D, 1, 1, 8'h15, 1, 0));
      seq.push_back(mk(8'hF0, 1, 1, 8'h15, 0, 0));
      seq.push_back(mk(8'h1D, 1, 1, 8'h15, 0, 0));
      seq.push_back(mk(8'hF0, 1, 1, 8'h15, 0, 0));
      seq.push_back(mk(8'h2D, 1, 1, 8'h00, 0, 0));
      foreach (seq[i]) begin
         p0 = pulseCount; e0 = errCount;
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         vectors++;
         if (keycode !== exp.kc) begin
            miscompares++;
            $display("[TB] FAIL overlap[%0d] keycode: got %h expected %h", i, keycode, exp.kc);
         end
         vectors++;
         if (pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
            miscompares++;
            $display("[TB] FAIL overlap[%0d] pulses: got kp=%0d fe=%0d expected kp=%0d fe=%0d",
                     i, pulseCount - p0, errCount - e0, exp.pulses, exp.errs);
         end
      end
   endtask

   task automatic test_parity();
      frame_t seq[$];
      frame_t exp;
      int p0, e0;
      seq.push_back(mk(8'h2D, 0, 1, 8'h00, 0, 1));
      seq.push_back(mk(8'hF0, 1, 1, 8'h00, 0, 0));
      seq.push_back(mk(8'h2D, 0, 1, 8'h00, 0, 1));
      seq.push_back(mk(8'h2D, 1, 1, 8'h15, 1, 0));
      seq.push_back(mk(8'h1D, 1, 0, 8'h15, 0, 1));
      foreach (seq[i]) begin
         p0 = pulseCount; e0 = errCount;
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         vectors++;
         if (keycode !== exp.kc) begin
            miscompares++;
            $display("[TB] FAIL parity[%0d] keycode: got %h expected %h", i, keycode, exp.kc);
         end
         vectors++;
         if (pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
            miscompares++;
            $display("[TB] FAIL parity[%0d] pulses: got kp=%0d fe=%0d expected kp=%0d fe=%0d",
                     i, pulseCount - p0, errCount - e0, exp.pulses, exp.errs);
         end
      end
   endtask

   task automatic test_timeout();
      frame_t seq[$];
      frame_t exp;
      int p0, e0, fallAt;
      seq.push_back(mk(8'h1D, 1, 1, 8'h1A, 1, 0));
      seq.push_back(mk(8'hF0, 1, 1, 8'h1A, 0, 0));
      foreach (seq[i]) begin
         p0 = pulseCount; e0 = errCount;
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         vectors++;
         if (keycode !== exp.kc || pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
            miscompares++;
            $display("[TB] FAIL timeout_setup[%0d]: got kc=%h kp=%0d fe=%0d expected kc=%h kp=%0d fe=%0d",
                     i, keycode, pulseCount - p0, errCount - e0, exp.kc, exp.pulses, exp.errs);
         end
      end
      p0 = pulseCount; e0 = errCount;
      sendFrame(8'h2D, 1, 1, 6);
      fallAt = lastFallCyc;
      repeat (TIMEOUT) @(negedge Clk);
      vectors++;
      if (errCount - e0 != 1 || pulseCount != p0) begin
         miscompares++;
         $display("[TB] FAIL timeout_pulse: got fe=%0d kp=%0d expected fe=1 kp=0",
                  errCount - e0, pulseCount - p0);
      end
      vectors++;
      if (lastErrCyc != fallAt + 3 + TIMEOUT) begin
         miscompares++;
         $display("[TB] FAIL timeout_time: got %0d expected %0d", lastErrCyc - fallAt, 3 + TIMEOUT);
      end
      p0 = pulseCount; e0 = errCount;
      applyStimulus(mk(8'h2D, 1, 1, 8'h15, 1, 0));
      exp = sb.pop_front();
      vectors++;
      if (keycode !== exp.kc || pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
         miscompares++;
         $display("[TB] FAIL timeout_recover: got kc=%h kp=%0d fe=%0d expected kc=%h kp=%0d fe=%0d",
                  keycode, pulseCount - p0, errCount - e0, exp.kc, exp.pulses, exp.errs);
      end
   endtask

   task automatic test_ext_repeat();
      frame_t seq[$];
      frame_t exp;
      int p0, e0;
      seq.push_back(mk(8'h1C, 1, 1, 8'h04, 1, 0));
      seq.push_back(mk(8'hE0, 1, 1, 8'h04, 0, 0));
      seq.push_back(mk(8'h2D, 1, 1, 8'h04, 0, 0));
      seq.push_back(mk(8'h2D, 1, 1, 8'h15, 1, 0));
      seq.push_back(mk(8'h2D, 1, 1, 8'h15, 0, 0));
      seq.push_back(mk(8'h2D, 1, 1, 8'h15, 0, 0));
      seq.push_back(mk(8'h29, 1, 1, 8'h2C, 1, 0));
      seq.push_back(mk(8'h1B, 1, 1, 8'h16, 1, 0));
      seq.push_back(mk(8'h23, 1, 1, 8'h07, 1, 0));
      seq.push_back(mk(8'h15, 1, 1, 8'h07, 0, 0));
      seq.push_back(mk(8'hF0, 1, 1, 8'h07, 0, 0));
      seq.push_back(mk(8'h1B, 1, 1, 8'h07, 0, 0));
      seq.push_back(mk(8'hF0, 1, 1, 8'h07, 0, 0));
      seq.push_back(mk(8'h23, 1, 1, 8'h00, 0, 0));
      foreach (seq[i]) begin
         p0 = pulseCount; e0 = errCount;
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         vectors++;
         if (keycode !== exp.kc) begin
            miscompares++;
            $display("[TB] FAIL ext_repeat[%0d] keycode: got %h expected %h", i, keycode, exp.kc);
         end
         vectors++;
         if (pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
            miscompares++;
            $display("[TB] FAIL ext_repeat[%0d] pulses: got kp=%0d fe=%0d expected kp=%0d fe=%0d",
                     i, pulseCount - p0, errCount - e0, exp.pulses, exp.errs);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      frame_t exp;
      int p0, e0;
      p0 = pulseCount; e0 = errCount;
      applyStimulus(mk(8'h1C, 1, 1, 8'h04, 1, 0));
      exp = sb.pop_front();
      vectors++;
      if (keycode !== exp.kc || pulseCount - p0 != exp.pulses) begin
         miscompares++;
         $display("[TB] FAIL midreset_setup: got kc=%h kp=%0d expected kc=%h kp=%0d",
                  keycode, pulseCount - p0, exp.kc, exp.pulses);
      end
      sendFrame(8'h2D, 1, 1, 5);
      p0 = pulseCount; e0 = errCount;
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (TIMEOUT + 50) @(negedge Clk);
      vectors++;
      if (keycode !== 8'h00 || pulseCount != p0 || errCount != e0) begin
         miscompares++;
         $display("[TB] FAIL midreset_discard: got kc=%h kp=%0d fe=%0d expected kc=00 kp=0 fe=0",
                  keycode, pulseCount - p0, errCount - e0);
      end
      p0 = pulseCount; e0 = errCount;
      applyStimulus(mk(8'h2D, 1, 1, 8'h15, 1, 0));
      exp = sb.pop_front();
      vectors++;
      if (keycode !== exp.kc || pulseCount - p0 != exp.pulses || errCount - e0 != exp.errs) begin
         miscompares++;
         $display("[TB] FAIL midreset_recover: got kc=%h kp=%0d fe=%0d expected kc=%h kp=%0d fe=%0d",
                  keycode, pulseCount - p0, errCount - e0, exp.kc, exp.pulses, exp.errs);
      end
   endtask

   task automatic test_pulse_shape();
      vectors++;
      if (widthViol != 0 || overlapViol != 0) begin
         miscompares++;
         $display("[TB] FAIL pulse_shape: got wide=%0d together=%0d expected 0 0",
                  widthViol, overlapViol);
      end
   endtask

   initial begin
      test_reset();
      test_make_r();
      test_overlap();
      test_parity();
      test_timeout();
      test_ext_repeat();
      test_reset_mid_frame();
      test_pulse_shape();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
